sc_reg_shifter: RTL

Writable datapath register with a multi-cycle serial shift engine, the write/modify counterpart of the fixed read-only source registers in the micro-datapath. It captures a word from the C-bus on a load strobe, holds it, and on request shifts it left or right by a programmable amount at one bit per clock. The result is published continuously on its output bus, with busy/done handshake signals for the datapath control unit.

---
 rtl/sc_reg_shifter_pkg.sv | 17 +
 rtl/sc_reg_shifter_if.sv | 31 +++
 rtl/sc_reg_shifter_counter.sv | 30 +++
 rtl/sc_reg_shifter.sv | 90 +++++++++
 4 files changed

// File: rtl/sc_reg_shifter_pkg.sv
// Shared definitions for the shift-register datapath block: FSM state encoding and default widths.
package sc_reg_shifter_pkg;

  localparam int DATAWIDTH_BUS_DEFAULT = 32;
  localparam int SHAMT_WIDTH_DEFAULT   = 5;

  localparam logic [1:0] STATE_IDLE  = 2'd0;
  localparam logic [1:0] STATE_SHIFT = 2'd1;
  localparam logic [1:0] STATE_DONE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = STATE_IDLE,
    SHIFT = STATE_SHIFT,
    DONE  = STATE_DONE
  } state_e;

endpackage

// File: rtl/sc_reg_shifter_if.sv
// Control-unit side bundle of the shift register: load/clear/start strobes, write data and status.
interface sc_reg_shifter_if
  import sc_reg_shifter_pkg::*;
#(
  parameter int DATAWIDTH_BUS = DATAWIDTH_BUS_DEFAULT,
  parameter int SHAMT_WIDTH   = SHAMT_WIDTH_DEFAULT
) ();

  logic                     sc_reg_shifter_clear_InHigh;
  logic                     sc_reg_shifter_load_InHigh;
  logic [DATAWIDTH_BUS-1:0] sc_reg_shifter_data_InBus;
  logic                     sc_reg_shifter_start_InHigh;
  logic                     sc_reg_shifter_dir_InHigh;
  logic [SHAMT_WIDTH-1:0]   sc_reg_shifter_shamt_InBus;
  logic [DATAWIDTH_BUS-1:0] sc_reg_shifter_data_OutBus;
  logic                     sc_reg_shifter_busy_OutHigh;
  logic                     sc_reg_shifter_done_OutHigh;

  modport master (
    output sc_reg_shifter_clear_InHigh, sc_reg_shifter_load_InHigh, sc_reg_shifter_data_InBus,
           sc_reg_shifter_start_InHigh, sc_reg_shifter_dir_InHigh, sc_reg_shifter_shamt_InBus,
    input  sc_reg_shifter_data_OutBus, sc_reg_shifter_busy_OutHigh, sc_reg_shifter_done_OutHigh
  );

  modport slave (
    input  sc_reg_shifter_clear_InHigh, sc_reg_shifter_load_InHigh, sc_reg_shifter_data_InBus,
           sc_reg_shifter_start_InHigh, sc_reg_shifter_dir_InHigh, sc_reg_shifter_shamt_InBus,
    output sc_reg_shifter_data_OutBus, sc_reg_shifter_busy_OutHigh, sc_reg_shifter_done_OutHigh
  );

endinterface

// File: rtl/sc_reg_shifter_counter.sv
// Loadable down-counter tracking remaining shift steps; tc_o flags the last step (count == 1).
module sc_reg_shifter_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         tc_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i)      count_d = '0;
    else if (load_i)  count_d = load_val_i;
    else if (dec_i)   count_d = count_q - W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign tc_o = (count_q == W'(1));

endmodule

// File: rtl/sc_reg_shifter.sv
// Writable register with a one-bit-per-clock serial shifter and busy/done handshake.
// Define SC_REG_SHIFTER_ARITH_EN for arithmetic (sign-filling) right shifts; default is logical.
module sc_reg_shifter
  import sc_reg_shifter_pkg::*;
#(
  parameter int                       DATAWIDTH_BUS        = DATAWIDTH_BUS_DEFAULT,
  parameter int                       SHAMT_WIDTH          = SHAMT_WIDTH_DEFAULT,
  parameter logic [DATAWIDTH_BUS-1:0] DATA_REGSHIFTER_INIT = '0
) (
  input logic           sc_reg_shifter_CLOCK_50,
  input logic           sc_reg_shifter_RESET_InLow,
  sc_reg_shifter_if.slave bus
);

  state_e                   state_q, state_d;
  logic [DATAWIDTH_BUS-1:0] data_q, data_d, shifted;
  logic                     dir_q, dir_d;
  logic                     fill;
  logic                     cnt_clear, cnt_load, cnt_dec, cnt_tc;

`ifdef SC_REG_SHIFTER_ARITH_EN
  assign fill = data_q[DATAWIDTH_BUS-1];
`else
  assign fill = 1'b0;
`endif

  assign shifted = dir_q ? {fill, data_q[DATAWIDTH_BUS-1:1]}
                         : {data_q[DATAWIDTH_BUS-2:0], 1'b0};

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    dir_d     = dir_q;
    cnt_clear = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    if (bus.sc_reg_shifter_clear_InHigh) begin
      state_d   = IDLE;
      data_d    = DATA_REGSHIFTER_INIT;
      cnt_clear = 1'b1;
    end else begin
      case (state_q)
        SHIFT: begin
          // load/start are deliberately not queued while shifting
          data_d  = shifted;
          cnt_dec = 1'b1;
          if (cnt_tc) state_d = DONE;
        end
        IDLE, DONE: begin
          state_d = IDLE;
          if (bus.sc_reg_shifter_load_InHigh) begin
            data_d = bus.sc_reg_shifter_data_InBus;
          end else if (bus.sc_reg_shifter_start_InHigh) begin
            dir_d    = bus.sc_reg_shifter_dir_InHigh;
            cnt_load = 1'b1;
            state_d  = (bus.sc_reg_shifter_shamt_InBus == '0) ? DONE : SHIFT;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge sc_reg_shifter_CLOCK_50 or negedge sc_reg_shifter_RESET_InLow) begin
    if (!sc_reg_shifter_RESET_InLow) begin
      state_q <= IDLE;
      data_q  <= DATA_REGSHIFTER_INIT;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      dir_q   <= dir_d;
    end
  end

  sc_reg_shifter_counter #(.W(SHAMT_WIDTH)) u_counter (
    .clk        (sc_reg_shifter_CLOCK_50),
    .rst_n      (sc_reg_shifter_RESET_InLow),
    .clear_i    (cnt_clear),
    .load_i     (cnt_load),
    .load_val_i (bus.sc_reg_shifter_shamt_InBus),
    .dec_i      (cnt_dec),
    .tc_o       (cnt_tc)
  );

  assign bus.sc_reg_shifter_data_OutBus  = data_q;
  assign bus.sc_reg_shifter_busy_OutHigh = (state_q == SHIFT);
  assign bus.sc_reg_shifter_done_OutHigh = (state_q == DONE);

endmodule
